// File: rtl/svreal_accum_if.sv
// Handshake bundle between the svreal multiply stage, the frame accumulator and its consumer.
// Ports: in_value/in_valid/in_ready and frame_len form the sample side;
//        out_value/out_valid/out_ready/out_ovf form the frame-result side.
interface svreal_accum_if #(
  parameter int IN_WIDTH  = 18,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
);
  logic signed [IN_WIDTH-1:0]  in_value;
  logic                        in_valid;
  logic                        in_ready;
  logic        [LEN_WIDTH-1:0] frame_len;
  logic signed [ACC_WIDTH-1:0] out_value;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_ovf;

  // master: sample producer + result consumer; slave: the accumulator
  modport master (
    output in_value, in_valid, frame_len, out_ready,
    input  in_ready, out_value, out_valid, out_ovf
  );
  modport slave (
    input  in_value, in_valid, frame_len, out_ready,
    output in_ready, out_value, out_valid, out_ovf
  );
endinterface

// File: rtl/svreal_accum.sv
// Streaming saturating fixed-point frame accumulator (svreal format value * 2^exp).
// Ports: clk, rst_n (async active-low), bus (slave side of svreal_accum_if).
// Latency: result valid on the edge after the final accept; one in_ready bubble per frame
// because the block holds off input while a result waits for out_ready.
module svreal_accum #(
  parameter int IN_WIDTH  = 18,
  parameter int IN_EXP    = -10,
  parameter int ACC_WIDTH = 32,
  parameter int ACC_EXP   = -10,
  parameter int LEN_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  svreal_accum_if.slave  bus
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  // Wide enough that acc + aligned sample can never wrap before the clamp.
  localparam int WW  = ACC_WIDTH + IN_WIDTH + 2;
  localparam int SHL = (IN_EXP >= ACC_EXP) ? (IN_EXP - ACC_EXP) : 0;
  localparam int SHR = (IN_EXP >= ACC_EXP) ? 0 : (ACC_EXP - IN_EXP);

  localparam logic signed [WW-1:0] MAXW = {{(WW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] MINW = {{(WW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] MAXA = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MINA = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [0:0]                 state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]       cnt;
  logic [LEN_WIDTH-1:0]       len_q;
  logic                       ovf_q;
  logic signed [ACC_WIDTH-1:0] out_value_q;
  logic                       out_valid_q;
  logic                       out_ovf_q;

  logic                       accept;
  logic signed [WW-1:0]       ext, aligned, acc_ext, wide;
  logic                       clamp;
  logic signed [ACC_WIDTH-1:0] sat;
  logic [LEN_WIDTH-1:0]       eff_len, last_idx;
  logic                       is_final;
  logic                       ovf_next;

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_value = out_value_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ovf   = out_ovf_q;

  assign accept = bus.in_valid && (state == ACCUM);

  always_comb begin
    ext     = {{(WW-IN_WIDTH){bus.in_value[IN_WIDTH-1]}}, bus.in_value};
    // Only one of SHL/SHR is nonzero; >>> floors toward -infinity.
    aligned = (ext <<< SHL) >>> SHR;
    acc_ext = {{(WW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    wide    = acc_ext + aligned;
    clamp   = 1'b0;
    sat     = wide[ACC_WIDTH-1:0];
    if (wide > MAXW) begin
      sat   = MAXA;
      clamp = 1'b1;
    end else if (wide < MINW) begin
      sat   = MINA;
      clamp = 1'b1;
    end

    // The first sample of a frame uses the live frame_len; later ones use the latched copy.
    eff_len  = (cnt == '0) ? bus.frame_len : len_q;
    last_idx = (eff_len == '0) ? '0 : eff_len - LEN_WIDTH'(1);
    is_final = (cnt == last_idx);
    ovf_next = ((cnt == '0) ? 1'b0 : ovf_q) | clamp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (cnt == '0) len_q <= bus.frame_len;
            ovf_q <= ovf_next;
            if (is_final) begin
              out_value_q <= sat;
              out_ovf_q   <= ovf_next;
              out_valid_q <= 1'b1;
              acc         <= '0;
              cnt         <= '0;
              state       <= HOLD;
            end else begin
              acc <= sat;
              cnt <= cnt + LEN_WIDTH'(1);
            end
          end
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svreal_accum.sv
module tb_svreal_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // d0: unity/mixed/backpressure/reset, d1: exponent down-shift, d2: narrow saturation
  svreal_accum_if #(.IN_WIDTH(18), .ACC_WIDTH(24), .LEN_WIDTH(16)) b0 ();
  svreal_accum_if #(.IN_WIDTH(18), .ACC_WIDTH(32), .LEN_WIDTH(16)) b1 ();
  svreal_accum_if #(.IN_WIDTH(18), .ACC_WIDTH(20), .LEN_WIDTH(16)) b2 ();

  svreal_accum #(.ACC_WIDTH(24)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  svreal_accum #(.ACC_EXP(-8))   u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  svreal_accum #(.ACC_WIDTH(20)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  function automatic logic rdy(input int d);
    case (d)
      0: rdy = b0.in_ready;
      1: rdy = b1.in_ready;
      default: rdy = b2.in_ready;
    endcase
  endfunction

  task automatic set_in(input int d, input int v, input int len, input logic vld);
    case (d)
      0: begin b0.in_value = v[17:0]; b0.frame_len = len[15:0]; b0.in_valid = vld; end
      1: begin b1.in_value = v[17:0]; b1.frame_len = len[15:0]; b1.in_valid = vld; end
      default: begin b2.in_value = v[17:0]; b2.frame_len = len[15:0]; b2.in_valid = vld; end
    endcase
  endtask

  // Offer one sample and return #1 after the edge that accepted it.
  task automatic push(input int d, input int v, input int len);
    int k = 0;
    set_in(d, v, len, 1'b1);
    while (!rdy(d) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 20) begin
      tests++; fails++;
      $display("FAIL push_timeout dut%0d: in_ready stayed 0, required 1", d);
    end else begin
      @(posedge clk); #1;
    end
    set_in(d, 0, len, 1'b0);
  endtask

  task automatic ack(input int d);
    case (d)
      0: b0.out_ready = 1'b1;
      1: b1.out_ready = 1'b1;
      default: b2.out_ready = 1'b1;
    endcase
    @(posedge clk); #1;
    b0.out_ready = 1'b0; b1.out_ready = 1'b0; b2.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (b0.out_value !== 24'd0) begin fails++; $display("FAIL reset_out_value got %0d want 0", b0.out_value); end
    tests++; if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b2.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b%b%b want 000", b0.out_valid, b1.out_valid, b2.out_valid); end
    tests++; if (b0.out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf got %b want 0", b0.out_ovf); end
    tests++; if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1 || b2.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b%b%b want 111", b0.in_ready, b1.in_ready, b2.in_ready); end
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unity;
    for (int i = 0; i < 3; i++) begin
      push(0, 1024, 4);
      tests++; if (b0.out_valid !== 1'b0) begin fails++; $display("FAIL unity_early_valid after sample %0d got %b want 0", i, b0.out_valid); end
    end
    push(0, 1024, 4);
    tests++; if (b0.out_valid !== 1'b1) begin fails++; $display("FAIL unity_valid got %b want 1", b0.out_valid); end
    tests++; if ($signed(b0.out_value) !== 4096) begin fails++; $display("FAIL unity_value got %0d want 4096", $signed(b0.out_value)); end
    tests++; if (b0.out_ovf !== 1'b0) begin fails++; $display("FAIL unity_ovf got %b want 0", b0.out_ovf); end
    tests++; if (b0.in_ready !== 1'b0) begin fails++; $display("FAIL unity_in_ready_hold got %b want 0", b0.in_ready); end
    ack(0);
  endtask

  task automatic test_signed_mix;
    push(0, -512, 2);
    push(0, 2304, 2);
    tests++; if ($signed(b0.out_value) !== 1792 || b0.out_valid !== 1'b1) begin fails++; $display("FAIL signed_mix got %0d valid %b want 1792 valid 1", $signed(b0.out_value), b0.out_valid); end
    tests++; if (b0.out_ovf !== 1'b0) begin fails++; $display("FAIL signed_mix_ovf got %b want 0", b0.out_ovf); end
    ack(0);
  endtask

  task automatic test_frame_len;
    // frame_len is latched on the first sample only
    push(0, 10, 3);
    push(0, 20, 1);
    tests++; if (b0.out_valid !== 1'b0) begin fails++; $display("FAIL len_latch_early got valid %b want 0", b0.out_valid); end
    push(0, 30, 1);
    tests++; if ($signed(b0.out_value) !== 60 || b0.out_valid !== 1'b1) begin fails++; $display("FAIL len_latch got %0d valid %b want 60 valid 1", $signed(b0.out_value), b0.out_valid); end
    ack(0);
    // frame_len of 0 behaves as 1
    push(0, 77, 0);
    tests++; if ($signed(b0.out_value) !== 77 || b0.out_valid !== 1'b1) begin fails++; $display("FAIL len_zero got %0d valid %b want 77 valid 1", $signed(b0.out_value), b0.out_valid); end
    ack(0);
  endtask

  task automatic test_down_shift;
    push(1, 1025, 1);
    tests++; if ($signed(b1.out_value) !== 256 || b1.out_valid !== 1'b1) begin fails++; $display("FAIL downshift_pos got %0d valid %b want 256 valid 1", $signed(b1.out_value), b1.out_valid); end
    ack(1);
    push(1, -1, 1);
    tests++; if ($signed(b1.out_value) !== -1) begin fails++; $display("FAIL downshift_floor got %0d want -1", $signed(b1.out_value)); end
    ack(1);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) push(2, 131071, 5);
    tests++; if ($signed(b2.out_value) !== 524287 || b2.out_valid !== 1'b1) begin fails++; $display("FAIL sat_value got %0d valid %b want 524287 valid 1", $signed(b2.out_value), b2.out_valid); end
    tests++; if (b2.out_ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf got %b want 1", b2.out_ovf); end
    ack(2);
    push(2, 3, 1);
    tests++; if ($signed(b2.out_value) !== 3 || b2.out_ovf !== 1'b0) begin fails++; $display("FAIL sat_recover got %0d ovf %b want 3 ovf 0", $signed(b2.out_value), b2.out_ovf); end
    ack(2);
  endtask

  task automatic test_backpressure;
    int bad = 0;
    push(0, 100, 1);
    set_in(0, 999, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ($signed(b0.out_value) !== 100 || b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold %0d bad cycles, last value %0d valid %b in_ready %b want 100 1 0", bad, $signed(b0.out_value), b0.out_valid, b0.in_ready); end
    set_in(0, 0, 1, 1'b0);
    b0.out_ready = 1'b1;
    @(posedge clk); #1;
    b0.out_ready = 1'b0;
    tests++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got valid %b in_ready %b want 0 1", b0.out_valid, b0.in_ready); end
    tests++; if ($signed(b0.out_value) !== 100) begin fails++; $display("FAIL bp_value_kept got %0d want 100", $signed(b0.out_value)); end
    push(0, 5, 1);
    tests++; if ($signed(b0.out_value) !== 5) begin fails++; $display("FAIL bp_no_consume got %0d want 5", $signed(b0.out_value)); end
    ack(0);
  endtask

  task automatic test_mid_frame_reset;
    push(0, 1024, 4);
    push(0, 1024, 4);
    rst_n = 1'b0;
    #1;
    tests++; if (b0.out_value !== 24'd0 || b0.out_valid !== 1'b0 || b0.out_ovf !== 1'b0 || b0.in_ready !== 1'b1) begin fails++; $display("FAIL rst_async got value %0d valid %b ovf %b in_ready %b want 0 0 0 1", $signed(b0.out_value), b0.out_valid, b0.out_ovf, b0.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(0, 512, 1);
    tests++; if ($signed(b0.out_value) !== 512 || b0.out_valid !== 1'b1) begin fails++; $display("FAIL rst_restart got %0d valid %b want 512 valid 1", $signed(b0.out_value), b0.out_valid); end
    ack(0);
  endtask

  initial begin
    set_in(0, 0, 1, 1'b0); set_in(1, 0, 1, 1'b0); set_in(2, 0, 1, 1'b0);
    b0.out_ready = 1'b0; b1.out_ready = 1'b0; b2.out_ready = 1'b0;
    test_reset();
    test_unity();
    test_signed_mix();
    test_frame_len();
    test_down_shift();
    test_saturation();
    test_backpressure();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
